// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, RAM I/O opcodes, and bridge command/state types.
// Pure declarations; no latency or backpressure of its own.
package mcs4;

    typedef logic [3:0] char_t;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef enum logic [3:0] {
        WRM = 4'h0,
        WMP = 4'h1,
        WRR = 4'h2,
        WPM = 4'h3,
        WR0 = 4'h4,
        WR1 = 4'h5,
        WR2 = 4'h6,
        WR3 = 4'h7,
        SBM = 4'h8,
        RDM = 4'h9,
        RDR = 4'hA,
        ADM = 4'hB,
        RD0 = 4'hC,
        RD1 = 4'hD,
        RD2 = 4'hE,
        RD3 = 4'hF
    } ioram_opa_t;

    localparam char_t Opr_io = 4'hE;

    typedef struct packed {
        ioram_opa_t opa;
        logic [1:0] chip;
        logic [1:0] rg;
        char_t      chr;
        char_t      data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SRC  = 2'd2,
        ST_IO   = 2'd3
    } bridge_state_t;

    // The upper opcode bit separates the read class (data returns on the bus) from writes.
    function automatic logic is_ram_read(input ioram_opa_t opa);
        return opa[3];
    endfunction

endpackage

// File: rtl/mcs4_timing_gen.sv
// Free-running 8-phase instruction-cycle generator with sync at X3 and a synced flag after the first X3.
// Latency: sync is a decode of the registered phase; no backpressure, runs every clock.
module mcs4_timing_gen
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output instr_cyc_t phase,
    output logic       sync,
    output logic       synced
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= A1;
            synced <= 1'b0;
        end else begin
            phase <= instr_cyc_t'(phase + 3'd1);
            if (phase == X3) begin
                synced <= 1'b1;
            end
        end
    end

    assign sync = (phase == X3);

endmodule

// File: rtl/mcs4_ram_bridge.sv
// Host-to-MCS-4 RAM bridge: each accepted command becomes an SRC cycle then an I/O cycle on the 4-bit bus.
// Latency: 16 clks from a phase-7 accept to rsp_valid (+ wait to phase 7 otherwise); cmd_ready only in IDLE or the final IO clk.
module mcs4_ram_bridge
    import mcs4::*;
#(
    parameter char_t OPR_IO     = Opr_io,
    parameter bit    RSP_WRITES = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  ioram_opa_t cmd_opa,
    input  logic [1:0] cmd_chip,
    input  logic [1:0] cmd_reg,
    input  logic [3:0] cmd_char,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       sync,
    output logic       cm_ram,
    output char_t      dbus_out,
    input  char_t      dbus_in
);

    instr_cyc_t    phase;
    logic          synced;
    bridge_state_t state;
    bridge_state_t state_nxt;
    cmd_t          cmd_q;
    logic          accept;
    logic          at_x3;
    logic          cmd_is_read;
    logic          respond_en;

    mcs4_timing_gen u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .phase  (phase),
        .sync   (sync),
        .synced (synced)
    );

    assign at_x3       = (phase == X3);
    assign cmd_is_read = is_ram_read(cmd_q.opa);
    assign respond_en  = cmd_is_read || RSP_WRITES;

    // A new command may overlap the last IO clk so back-to-back commands cost exactly 16 clks.
    assign cmd_ready = synced && ((state == ST_IDLE) || ((state == ST_IO) && at_x3));
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == ST_IO) && at_x3 && respond_en;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = at_x3 ? ST_SRC : ST_PEND;
                end
            end
            ST_PEND: begin
                if (at_x3) begin
                    state_nxt = ST_SRC;
                end
            end
            ST_SRC: begin
                if (at_x3) begin
                    state_nxt = ST_IO;
                end
            end
            ST_IO: begin
                if (at_x3) begin
                    state_nxt = accept ? ST_SRC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            rsp_data <= 4'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q.opa  <= cmd_opa;
                cmd_q.chip <= cmd_chip;
                cmd_q.rg   <= cmd_reg;
                cmd_q.chr  <= cmd_char;
                cmd_q.data <= cmd_data;
            end
            // Only commands that will respond update rsp_data, so a silent write keeps the last read.
            if ((state == ST_IO) && (phase == X2) && respond_en) begin
                rsp_data <= cmd_is_read ? dbus_in : 4'h0;
            end
        end
    end

    always_comb begin
        cm_ram   = 1'b0;
        dbus_out = 4'h0;
        case (state)
            ST_SRC: begin
                if (phase == X2) begin
                    cm_ram   = 1'b1;
                    dbus_out = {cmd_q.chip, cmd_q.rg};
                end else if (phase == X3) begin
                    dbus_out = cmd_q.chr;
                end
            end
            ST_IO: begin
                case (phase)
                    M1: dbus_out = OPR_IO;
                    M2: begin
                        cm_ram   = 1'b1;
                        dbus_out = cmd_q.opa;
                    end
                    X2: dbus_out = cmd_is_read ? 4'h0 : cmd_q.data;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcs4_ram_bridge.sv
// Bench for mcs4_ram_bridge: directed commands, scoreboard of bus/response expectations, i4002-like slave.
// Expectations are pushed at accept time and checked every negedge by an independent monitor.
module tb_mcs4_ram_bridge;
    import mcs4::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    ioram_opa_t cmd_opa = WRM;
    logic [1:0] cmd_chip = 2'd0;
    logic [1:0] cmd_reg = 2'd0;
    logic [3:0] cmd_char = 4'h0;
    logic [3:0] cmd_data = 4'h0;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       sync;
    logic       cm_ram;
    char_t      dbus_out;
    char_t      dbus_in;

    always #5 clk = ~clk;

    mcs4_ram_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opa   (cmd_opa),
        .cmd_chip  (cmd_chip),
        .cmd_reg   (cmd_reg),
        .cmd_char  (cmd_char),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .sync      (sync),
        .cm_ram    (cm_ram),
        .dbus_out  (dbus_out),
        .dbus_in   (dbus_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [2:0] ph;

    typedef struct {
        int         cyc;
        logic [3:0] data;
    } rsp_t;

    rsp_t       rsp_q[$];
    logic [4:0] exp_bus[int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference phase: counts clocks since reset release, independent of the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 3'd0;
        else        ph <= ph + 3'd1;
    end

    // i4002-style slave: tracks SRC address and I/O opcode, stores WRM data, answers RDM and RD0-3.
    logic [3:0] mem  [256];
    logic [3:0] stat [64];
    logic [3:0] s_cr;
    logic [3:0] s_char;
    logic [3:0] s_opa;
    logic       s_src;
    logic       s_io;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        for (int i = 0; i < 64; i++) stat[i] = 4'h0;
        stat[{2'd3, 2'd0, 2'd2}] = 4'h3;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cr <= 4'h0; s_char <= 4'h0; s_opa <= 4'h0; s_src <= 1'b0; s_io <= 1'b0;
        end else begin
            if (ph == 3'd6 && cm_ram) begin s_cr <= dbus_out; s_src <= 1'b1; end
            if (ph == 3'd7 && s_src) begin s_char <= dbus_out; s_src <= 1'b0; end
            if (ph == 3'd4 && cm_ram) begin s_opa <= dbus_out; s_io <= 1'b1; end
            if (ph == 3'd6 && s_io) begin
                if (s_opa == 4'h0) mem[{s_cr, s_char}] <= dbus_out;
                s_io <= 1'b0;
            end
        end
    end

    always_comb begin
        dbus_in = 4'h0;
        if (ph == 3'd6 && s_io && s_opa[3]) begin
            if (s_opa == 4'h9)       dbus_in = mem[{s_cr, s_char}];
            else if (s_opa >= 4'hC)  dbus_in = stat[{s_cr, s_opa[1:0]}];
        end
    end

    // Monitor: sync against the reference phase, bus against the expected schedule, responses against the queue.
    always @(negedge clk) begin
        rsp_t r;
        chk("sync", sync, ph == 3'd7);
        if (exp_bus.exists(cyc)) begin
            chk("cm_ram", cm_ram, exp_bus[cyc][4]);
            chk("dbus_out", dbus_out, exp_bus[cyc][3:0]);
        end else begin
            chk("cm_ram_quiet", cm_ram, 1'b0);
            chk("dbus_quiet", dbus_out, 4'h0);
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 data=%0h expected no response (cycle %0d)", rsp_data, cyc);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_cycle", cyc, r.cyc);
                chk("rsp_data", rsp_data, r.data);
            end
        end else if (rsp_q.size() > 0 && cyc >= rsp_q[0].cyc) begin
            r = rsp_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL rsp_missing: got no rsp_valid expected one at cycle %0d (now %0d)", r.cyc, cyc);
        end
    end

    // Drive one command, wait for acceptance, then scramble inputs to prove the DUT latched them.
    task automatic send(input ioram_opa_t opa, input logic [1:0] chip, input logic [1:0] rg,
                        input logic [3:0] chr, input logic [3:0] dat, input logic [3:0] rdat,
                        output int src, output int acc);
        bit ok = 0;
        int p = 0;
        cmd_opa = opa; cmd_chip = chip; cmd_reg = rg; cmd_char = chr; cmd_data = dat;
        cmd_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1; acc = cyc; p = int'(ph);
            end
        end
        src = acc + 1 + (7 - p);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 200 clks expected acceptance");
        end else begin
            exp_bus[src + 6]  = {1'b1, chip, rg};
            exp_bus[src + 7]  = {1'b0, chr};
            exp_bus[src + 11] = {1'b0, 4'hE};
            exp_bus[src + 12] = {1'b1, 4'(opa)};
            exp_bus[src + 14] = {1'b0, (opa[3] ? 4'h0 : dat)};
            rsp_q.push_back('{src + 15, (opa[3] ? rdat : 4'h0)});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_opa  = ioram_opa_t'($urandom_range(15));
        cmd_chip = 2'($urandom_range(3));
        cmd_reg  = 2'($urandom_range(3));
        cmd_char = 4'($urandom_range(15));
        cmd_data = 4'($urandom_range(15));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && rsp_q.size() != 0; k++) @(posedge clk);
        if (rsp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", rsp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        @(posedge clk); #1;
        for (int k = 0; k < 8 && ph != p; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_ready_ramp(input string nm);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk(nm, cmd_ready, k >= 8);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int s1, s2, a1, a2;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_ready_ramp("cmd_ready_startup");

        send(WRM, 2'd1, 2'd2, 4'h5, 4'hA, 4'h0, s1, a1);
        drain();
        send(RDM, 2'd1, 2'd2, 4'h5, 4'h0, 4'hA, s1, a1);
        drain();
        send(RD2, 2'd3, 2'd0, 4'h0, 4'h0, 4'h3, s1, a1);
        drain();

        send(WR1, 2'd2, 2'd1, 4'h4, 4'h7, 4'h0, s1, a1);
        send(RDM, 2'd1, 2'd2, 4'h5, 4'h0, 4'hA, s2, a2);
        chk("b2b_accept_gap", a2 - a1, (s1 + 15) - a1);
        chk("b2b_src_gap", s2 - s1, 16);
        drain();

        wait_phase(3'd2);
        send(WRM, 2'd0, 2'd3, 4'h9, 4'h5, 4'h0, s1, a1);
        chk("pend_accept_phase", (s1 - a1), 6);
        drain();
        send(RDM, 2'd0, 2'd3, 4'h9, 4'h0, 4'h5, s1, a1);
        drain();

        send(RDM, 2'd1, 2'd2, 4'h5, 4'h0, 4'hA, s1, a1);
        while (cyc < s1 + 13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_bus.delete();
        rsp_q.delete();
        chk("rst_sync", sync, 1'b0);
        chk("rst_cm_ram", cm_ram, 1'b0);
        chk("rst_dbus_out", dbus_out, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 4'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_ready_ramp("cmd_ready_after_reset");

        send(RDM, 2'd1, 2'd2, 4'h5, 4'h0, 4'hA, s1, a1);
        drain();
        repeat (10) @(posedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
